// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 encodings, FSM states and fault causes for the
//               load/store controller and the data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] FN3_LB  = 3'b000;
    localparam logic [2:0] FN3_LH  = 3'b001;
    localparam logic [2:0] FN3_LW  = 3'b010;
    localparam logic [2:0] FN3_LBU = 3'b100;
    localparam logic [2:0] FN3_LHU = 3'b101;
    localparam logic [2:0] FN3_SB  = 3'b000;
    localparam logic [2:0] FN3_SH  = 3'b001;
    localparam logic [2:0] FN3_SW  = 3'b010;

    localparam logic [31:0] MMIO_TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] MMIO_STATUS_OFS = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_MMIO_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_MISALIGN  = 2'd1,
        CAUSE_ACCESS    = 2'd2,
        CAUSE_ILLEGAL   = 2'd3
    } lsu_cause_t;

endpackage

`default_nettype wire

// File: rtl/lsu_addr_decode.sv
// ============================================================================
// Module      : lsu_addr_decode
// Description : Combinational request checker: funct3 legality, alignment,
//               DMEM/UART window select and prioritised fault cause.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_addr_decode
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = 32'h8000_2000,
    parameter int          DMEM_WORDS = 8192,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        we,
    input  logic [2:0]  fn3,
    input  logic [31:0] addr,
    output logic        in_dmem,
    output logic        fault,
    output logic [1:0]  cause
);

    localparam logic [32:0] c_DMEM_BYTES = 33'(DMEM_WORDS) * 33'd4;

    logic [31:0] w_dmem_off;
    logic [31:0] w_mmio_off;
    logic        w_fn3_legal;
    logic        w_misaligned;
    logic        w_mmio_ok;
    lsu_cause_t  w_cause;

    // Lower-bound compare first so addresses below the base never wrap in
    assign w_dmem_off = addr - DMEM_BASE;
    assign w_mmio_off = addr - MMIO_BASE;
    assign in_dmem    = (addr >= DMEM_BASE) && ({1'b0, w_dmem_off} < c_DMEM_BYTES);

    assign w_misaligned = ((fn3[1:0] == 2'b01) && addr[0]) ||
                          ((fn3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    assign w_mmio_ok = (addr >= MMIO_BASE) &&
                       (( we && ((fn3 == FN3_SW) || (fn3 == FN3_SB)) && (w_mmio_off == MMIO_TXDATA_OFS)) ||
                        (!we && (fn3 == FN3_LW) && (w_mmio_off == MMIO_STATUS_OFS)));

    always_comb begin
        w_fn3_legal = 1'b0;
        if (we) begin
            w_fn3_legal = fn3 inside {FN3_SB, FN3_SH, FN3_SW};
        end else begin
            w_fn3_legal = fn3 inside {FN3_LB, FN3_LH, FN3_LW, FN3_LBU, FN3_LHU};
        end
    end

    always_comb begin
        w_cause = CAUSE_NONE;
        if (!w_fn3_legal) begin
            w_cause = CAUSE_ILLEGAL;
        end else if (w_misaligned) begin
            w_cause = CAUSE_MISALIGN;
        end else if (!in_dmem && !w_mmio_ok) begin
            w_cause = CAUSE_ACCESS;
        end
    end

    assign cause = w_cause;
    assign fault = (w_cause != CAUSE_NONE);

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store controller routing execute-stage requests to DMEM
//               or the UART MMIO window. Define LSU_PERF_EN for the
//               load/store/fault performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = 32'h8000_2000,
    parameter int          DMEM_WORDS = 8192,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_fn3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic [1:0]  resp_cause,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_wr_en,
    output logic [2:0]  dmem_fn3,
    input  logic [31:0] dmem_rdata,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready
`ifdef LSU_PERF_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_faults
`endif
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;
    logic        w_accept;
    logic        w_in_dmem;
    logic        w_fault;
    logic [1:0]  w_cause;
    logic [31:0] w_addr_sel;

    logic [31:0] r_addr;
    logic [2:0]  r_fn3;
    logic [7:0]  r_tx_byte;
    logic [4:0]  r_rd;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic [1:0]  r_resp_cause;

    lsu_addr_decode #(
        .DMEM_BASE  (DMEM_BASE),
        .DMEM_WORDS (DMEM_WORDS),
        .MMIO_BASE  (MMIO_BASE)
    ) u_decode (
        .we      (req_we),
        .fn3     (req_fn3),
        .addr    (req_addr),
        .in_dmem (w_in_dmem),
        .fault   (w_fault),
        .cause   (w_cause)
    );

    assign req_ready  = (r_state == ST_IDLE);
    assign w_accept   = req_ready && req_valid;

    // DMEM sees the live request in IDLE so its registered read starts on the accept edge
    assign w_addr_sel = req_ready ? req_addr : r_addr;
    assign dmem_addr  = w_addr_sel - DMEM_BASE;
    assign dmem_fn3   = req_ready ? req_fn3 : r_fn3;
    assign dmem_wdata = req_wdata;
    assign dmem_wr_en = w_accept && req_we && !w_fault && w_in_dmem;

    assign uart_tx_valid = (r_state == ST_MMIO_WAIT);
    assign uart_tx_data  = r_tx_byte;

    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_resp_data;
    assign resp_rd    = r_rd;
    assign resp_err   = r_resp_err;
    assign resp_cause = r_resp_cause;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_state_nxt = ST_RESP;
                    end else if (w_in_dmem) begin
                        w_state_nxt = req_we ? ST_RESP : ST_LOAD_WAIT;
                    end else begin
                        w_state_nxt = req_we ? ST_MMIO_WAIT : ST_RESP;
                    end
                end
            end
            ST_LOAD_WAIT: w_state_nxt = ST_RESP;
            ST_MMIO_WAIT: begin
                if (uart_tx_ready) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= 32'b0;
            r_fn3        <= 3'b0;
            r_tx_byte    <= 8'b0;
            r_rd         <= 5'b0;
            r_resp_data  <= 32'b0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= 2'b0;
        end else if (w_accept) begin
            r_addr       <= req_addr;
            r_fn3        <= req_fn3;
            r_tx_byte    <= req_wdata[7:0];
            r_rd         <= req_rd;
            r_resp_err   <= w_fault;
            r_resp_cause <= w_cause;
            // Only a legal non-DMEM load reaches here as STATUS; all else returns 0 unless DMEM fills it
            r_resp_data  <= (!w_fault && !w_in_dmem && !req_we) ? {31'b0, uart_tx_ready} : 32'b0;
        end else if (r_state == ST_LOAD_WAIT) begin
            r_resp_data  <= dmem_rdata;
        end
    end

`ifdef LSU_PERF_EN
    logic        r_we;
    logic [31:0] r_perf_loads;
    logic [31:0] r_perf_stores;
    logic [31:0] r_perf_faults;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we          <= 1'b0;
            r_perf_loads  <= 32'b0;
            r_perf_stores <= 32'b0;
            r_perf_faults <= 32'b0;
        end else begin
            if (w_accept) begin
                r_we <= req_we;
            end
            if (resp_valid && resp_ready) begin
                if (r_resp_err) begin
                    r_perf_faults <= r_perf_faults + 32'd1;
                end else if (r_we) begin
                    r_perf_stores <= r_perf_stores + 32'd1;
                end else begin
                    r_perf_loads  <= r_perf_loads + 32'd1;
                end
            end
        end
    end

    assign perf_loads  = r_perf_loads;
    assign perf_stores = r_perf_stores;
    assign perf_faults = r_perf_faults;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl with a byte-level DMEM and a
//               response-timeline model; LSU_PERF_EN adds counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

    localparam logic [31:0] DMEM_BASE  = 32'h8000_2000;
    localparam int          DMEM_WORDS = 8192;
    localparam logic [31:0] MMIO_BASE  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_fn3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [1:0]  resp_cause;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_wr_en;
    logic [2:0]  dmem_fn3;
    logic        uart_tx_valid, uart_tx_ready;
    logic [7:0]  uart_tx_data;
`ifdef LSU_PERF_EN
    logic [31:0] perf_loads, perf_stores, perf_faults;
`endif

    always #5 clk = ~clk;

    lsu_ctrl #(.DMEM_BASE(DMEM_BASE), .DMEM_WORDS(DMEM_WORDS), .MMIO_BASE(MMIO_BASE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_fn3(req_fn3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err), .resp_cause(resp_cause),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wr_en(dmem_wr_en),
        .dmem_fn3(dmem_fn3), .dmem_rdata(dmem_rdata),
        .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready)
`ifdef LSU_PERF_EN
        , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_faults(perf_faults)
`endif
    );

    // Data memory: byte array, registered read with sign handling by funct3
    logic [7:0] dmem [0:32767];

    function automatic logic [31:0] dmem_read(input logic [31:0] a, input logic [2:0] f);
        int i;
        logic [7:0] b0, b1, b2, b3;
        i  = int'(a[14:0]);
        b0 = dmem[i];
        b1 = dmem[(i + 1) & 32767];
        b2 = dmem[(i + 2) & 32767];
        b3 = dmem[(i + 3) & 32767];
        case (f)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'b0, b0};
            3'b101:  return {16'b0, b1, b0};
            default: return 32'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (dmem_wr_en) begin
            for (int k = 0; k < (1 << dmem_fn3[1:0]); k++)
                dmem[(int'(dmem_addr[14:0]) + k) & 32767] <= dmem_wdata[8*k +: 8];
        end
        dmem_rdata <= dmem_read(dmem_addr, dmem_fn3);
    end

    int n_hs = 0, n_txv = 0;
    always @(posedge clk) begin
        if (uart_tx_valid && uart_tx_ready) n_hs <= n_hs + 1;
        if (uart_tx_valid) n_txv <= n_txv + 1;
    end

    // Reference model: address-keyed byte map plus architectural rules
    logic [7:0] model_mem [logic [31:0]];
    int m_loads = 0, m_stores = 0, m_faults = 0;

    function automatic bit m_in_dmem(input logic [31:0] a);
        logic [63:0] x;
        x = {32'b0, a};
        return (x >= {32'b0, DMEM_BASE}) && (x < {32'b0, DMEM_BASE} + 64'(DMEM_WORDS) * 4);
    endfunction

    function automatic logic [1:0] m_cause(input bit we, input logic [2:0] f, input logic [31:0] a);
        int size;
        bit legal;
        legal = we ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'd3;
        size = 1 << f[1:0];
        if ((a % size) != 0) return 2'd1;
        if (m_in_dmem(a)) return 2'd0;
        if (we && a == MMIO_BASE && (size == 4 || size == 1)) return 2'd0;
        if (!we && a == MMIO_BASE + 32'd4 && size == 4) return 2'd0;
        return 2'd2;
    endfunction

    function automatic logic [7:0] m_byte(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] m_load(input bit we, input logic [2:0] f, input logic [31:0] a,
                                           input logic [1:0] cause, input bit urdy);
        logic [63:0] v;
        int n;
        if (we || cause != 2'd0) return 32'b0;
        if (!m_in_dmem(a)) return {31'b0, urdy};
        n = 1 << f[1:0];
        v = 64'b0;
        for (int k = 0; k < n; k++) v = v + (64'(m_byte(a + k)) << (8 * k));
        if (!f[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    int n_checks = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic        chk_en = 1'b0;
    logic        exp_req_ready, exp_resp_valid, exp_wr_en, exp_tx_valid, exp_dmem_chk, exp_err;
    logic [31:0] exp_data, exp_dmem_addr;
    logic [4:0]  exp_rd;
    logic [1:0]  exp_cause;
    logic [7:0]  exp_tx_data;
    logic [2:0]  exp_dmem_fn3;

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", req_ready, exp_req_ready);
            check("resp_valid", resp_valid, exp_resp_valid);
            check("dmem_wr_en", dmem_wr_en, exp_wr_en);
            check("uart_tx_valid", uart_tx_valid, exp_tx_valid);
            if (exp_tx_valid) check("uart_tx_data", uart_tx_data, exp_tx_data);
            if (exp_dmem_chk) begin
                check("dmem_addr", dmem_addr, exp_dmem_addr);
                check("dmem_fn3", dmem_fn3, exp_dmem_fn3);
            end
            if (exp_resp_valid) begin
                check("resp_data", resp_data, exp_data);
                check("resp_rd", resp_rd, exp_rd);
                check("resp_err", resp_err, exp_err);
                check("resp_cause", resp_cause, exp_cause);
            end
        end
    end

    logic [31:0] last_data;
    logic [4:0]  last_rd;
    logic [1:0]  last_cause;

    task automatic set_idle();
        exp_req_ready = 1'b1; exp_resp_valid = 1'b0; exp_wr_en = 1'b0;
        exp_tx_valid = 1'b0; exp_dmem_chk = 1'b0;
    endtask

    // Called just after a clock edge with the DUT idle; returns likewise
    task automatic do_req(input bit we, input logic [2:0] fn3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int ustall,
                          input bit urdy, input int rstall, input bit abort);
        logic [1:0]  cause;
        logic [31:0] edata;
        bit dm, mmst;
        int lat;
        cause = m_cause(we, fn3, addr);
        dm    = m_in_dmem(addr);
        mmst  = (cause == 2'd0) && we && !dm;
        edata = m_load(we, fn3, addr, cause, urdy);
        lat   = (cause != 2'd0) ? 1 : mmst ? ustall + 2 : (dm && !we) ? 2 : 1;
        if (cause == 2'd0 && we && dm)
            for (int k = 0; k < (1 << fn3[1:0]); k++) model_mem[addr + k] = wdata[8*k +: 8];

        req_valid = 1'b1; req_we = we; req_fn3 = fn3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        uart_tx_ready = mmst ? (ustall == 0) : urdy;
        exp_req_ready = 1'b1; exp_resp_valid = 1'b0; exp_tx_valid = 1'b0;
        exp_wr_en = (cause == 2'd0) && we && dm;
        exp_dmem_chk = 1'b1; exp_dmem_addr = addr - DMEM_BASE; exp_dmem_fn3 = fn3;
        exp_data = edata; exp_rd = rd; exp_err = (cause != 2'd0); exp_cause = cause;
        exp_tx_data = wdata[7:0];

        for (int c = 1; c <= lat + rstall; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                req_valid = 1'b0; req_we = ~we; req_fn3 = ~fn3; req_addr = ~addr;
                req_wdata = ~wdata; req_rd = ~rd;
            end
            exp_req_ready  = 1'b0;
            exp_wr_en      = 1'b0;
            exp_tx_valid   = mmst && (c < lat);
            exp_resp_valid = (c >= lat);
            if (mmst) uart_tx_ready = (c >= ustall + 1);
            if (c == lat) begin
                last_data = resp_data; last_rd = resp_rd; last_cause = resp_cause;
            end
            if (abort && c == lat) rst = 1'b1;
            resp_ready = !abort && (c == lat + rstall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b0;
        set_idle();
        if (abort) begin
            m_loads = 0; m_stores = 0; m_faults = 0;
        end else if (cause != 2'd0) m_faults++;
        else if (we) m_stores++;
        else m_loads++;
    endtask

    task automatic check_perf();
`ifdef LSU_PERF_EN
        check("perf_loads", perf_loads, m_loads);
        check("perf_stores", perf_stores, m_stores);
        check("perf_faults", perf_faults, m_faults);
`endif
    endtask

    int hs0, txv0;

    initial begin
        for (int i = 0; i < 32768; i++) dmem[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_fn3 = 3'b0; req_addr = 32'b0;
        req_wdata = 32'b0; req_rd = 5'b0; resp_ready = 1'b0; uart_tx_ready = 1'b0;
        set_idle();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_resp_data", resp_data, 32'h0);
        check("reset_resp_rd", resp_rd, 5'd0);
        check("reset_resp_err", resp_err, 1'b0);
        check("reset_resp_cause", resp_cause, 2'd0);

        do_req(1, 3'b010, 32'h8000_2004, 32'hDEAD_BEEF, 5'd1, 0, 0, 0, 0);
        do_req(0, 3'b010, 32'h8000_2004, 32'h0, 5'd5, 0, 0, 0, 0);
        check("lw_data_lit", last_data, 32'hDEAD_BEEF);
        check("lw_rd_lit", last_rd, 5'd5);

        do_req(1, 3'b000, 32'h8000_2003, 32'h0000_0080, 5'd2, 0, 0, 0, 0);
        check("model_lb_lit", m_load(0, 3'b000, 32'h8000_2003, 2'd0, 0), 32'hFFFF_FF80);
        do_req(0, 3'b000, 32'h8000_2003, 32'h0, 5'd6, 0, 0, 0, 0);
        check("lb_lit", last_data, 32'hFFFF_FF80);
        do_req(0, 3'b100, 32'h8000_2003, 32'h0, 5'd7, 0, 0, 0, 0);
        check("lbu_lit", last_data, 32'h0000_0080);
        do_req(0, 3'b001, 32'h8000_2002, 32'h0, 5'd8, 0, 0, 0, 0);
        check("lh_lit", last_data, 32'hFFFF_8000);
        do_req(0, 3'b101, 32'h8000_2006, 32'h0, 5'd9, 0, 0, 0, 0);
        check("lhu_lit", last_data, 32'h0000_DEAD);

        do_req(0, 3'b010, 32'h8000_2002, 32'h0, 5'd10, 0, 0, 0, 0);
        check("misalign_cause_lit", last_cause, 2'd1);
        do_req(0, 3'b011, 32'h8000_2000, 32'h0, 5'd11, 0, 0, 0, 0);
        check("illegal_cause_lit", last_cause, 2'd3);
        do_req(0, 3'b010, 32'h8000_1FFC, 32'h0, 5'd12, 0, 0, 0, 0);
        check("below_window_lit", last_cause, 2'd2);
        do_req(1, 3'b001, 32'h8000_2001, 32'h1234, 5'd13, 0, 0, 0, 0);
        do_req(1, 3'b100, 32'h8000_2000, 32'h1234, 5'd14, 0, 0, 0, 0);
        do_req(0, 3'b010, 32'h8000_A000, 32'h0, 5'd15, 0, 0, 0, 0);
        do_req(0, 3'b010, 32'h8000_9FFC, 32'h0, 5'd16, 0, 0, 0, 0);

        hs0 = n_hs; txv0 = n_txv;
        do_req(1, 3'b000, 32'h1000_0000, 32'h0000_0041, 5'd17, 3, 0, 0, 0);
        check("uart_handshakes", n_hs - hs0, 32'd1);
        check("uart_valid_cycles", n_txv - txv0, 32'd4);
        do_req(0, 3'b010, 32'h1000_0004, 32'h0, 5'd18, 0, 1, 0, 0);
        check("status_ready_lit", last_data, 32'h1);
        do_req(0, 3'b010, 32'h1000_0004, 32'h0, 5'd19, 0, 0, 0, 0);
        check("status_busy_lit", last_data, 32'h0);
        do_req(1, 3'b001, 32'h1000_0000, 32'h0, 5'd20, 0, 0, 0, 0);
        do_req(0, 3'b000, 32'h1000_0004, 32'h0, 5'd21, 0, 1, 0, 0);
        do_req(0, 3'b010, 32'h1000_0008, 32'h0, 5'd22, 0, 1, 0, 0);
        do_req(1, 3'b010, 32'h1000_0000, 32'h1234_5678, 5'd23, 0, 0, 0, 0);

        do_req(0, 3'b010, 32'h8000_2004, 32'h0, 5'd24, 0, 0, 5, 0);
        check_perf();

        do_req(0, 3'b010, 32'h8000_2004, 32'h0, 5'd25, 0, 0, 0, 1);
        @(negedge clk);
        check("abort_resp_data", resp_data, 32'h0);
        check("abort_resp_err", resp_err, 1'b0);
        check("abort_resp_rd", resp_rd, 5'd0);
        check_perf();
        @(posedge clk); #1;
        do_req(1, 3'b010, 32'h8000_2008, 32'hCAFE_F00D, 5'd26, 0, 0, 0, 0);
        do_req(0, 3'b010, 32'h8000_2008, 32'h0, 5'd27, 0, 0, 0, 0);
        check("post_reset_lw_lit", last_data, 32'hCAFE_F00D);
        check_perf();

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
